// File: rtl/sr_seq_unit.sv
// Multi-cycle right shifter: one binary-weighted stage per clock (16, 8, 4, 2, 1), logical or arithmetic.
// Optional rotate-right mode is built only when SR_ROTATE_EN is defined.
module sr_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    input  logic               in_rotate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for an operand, in_ready high
    // SHIFT | applying stage r_cnt (largest weight first)
    // DONE  | result held on out_data until out_ready
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [SHAMT_W-1:0] C_LAST = SHAMT_W'(SHAMT_W - 1);

    logic [1:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_arith;
    logic               r_sign;

    logic [SHAMT_W-1:0] w_idx;
    logic [SHAMT_W-1:0] w_amt;
    logic               w_stage_en;
    logic               w_fill;
    logic [2*WIDTH-1:0] w_shift_ext;
    logic [WIDTH-1:0]   w_next;

    assign w_idx      = C_LAST - r_cnt;
    assign w_amt      = SHAMT_W'(1) << w_idx;
    assign w_stage_en = r_shamt[w_idx];
    assign w_fill     = r_arith & r_sign;

    // Upper half of the extended vector supplies the vacated MSBs.
    assign w_shift_ext = {{WIDTH{w_fill}}, r_work} >> w_amt;

`ifdef SR_ROTATE_EN
    logic               r_rotate;
    logic [2*WIDTH-1:0] w_rot_ext;

    assign w_rot_ext = {r_work, r_work} >> w_amt;
    assign w_next    = r_rotate ? w_rot_ext[WIDTH-1:0] : w_shift_ext[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rotate <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_rotate <= in_rotate;
        end
    end
`else
    logic w_unused_rotate;

    assign w_unused_rotate = in_rotate;
    assign w_next          = w_shift_ext[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_shamt <= '0;
            r_arith <= 1'b0;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data;
                        r_shamt <= in_shamt;
                        r_arith <= in_arith;
                        r_sign  <= in_data[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_stage_en) begin
                        r_work <= w_next;
                    end
                    r_cnt <= r_cnt + SHAMT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_work;

endmodule

// File: tb/tb_sr_seq_unit.sv
// Self-checking bench for sr_seq_unit: directed cases plus randomized operations against a reference model.
// Expected rotate results follow SR_ROTATE_EN as seen by the bench.
module tb_sr_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_arith;
    logic        in_rotate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks;
    int n_errors;

    sr_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .in_rotate (in_rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input logic a, input logic r);
`ifdef SR_ROTATE_EN
        if (r) return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`endif
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation; hold = number of extra cycles out_ready stays low in DONE.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                         input logic r, input int hold, input string tag);
        logic [31:0] exp;
        int          n;
        exp = model(d, int'(s), a, r);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        in_arith  = a;
        in_rotate = r;
        tick();
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_shamt  = 5'($urandom);
        in_arith  = 1'($urandom);
        in_rotate = 1'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd5);
        chk({tag, "_data"}, out_data, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, out_data, exp);
            chk({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_arith  = 1'b0;
        in_rotate = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op(32'hFFFF_FFF8, 5'd1, 1'b0, 1'b0, 0, "logic1");
        chk("logic1_const", model(32'hFFFF_FFF8, 1, 1'b0, 1'b0), 32'h7FFF_FFFC);
        do_op(32'hFFFF_FFF8, 5'd3, 1'b1, 1'b0, 0, "arith3");
        do_op(32'h8000_0000, 5'd31, 1'b1, 1'b0, 0, "arith31");
        do_op(32'h8000_0000, 5'd31, 1'b0, 1'b0, 0, "logic31");
        do_op(32'h7FFF_FFFF, 5'd4, 1'b1, 1'b0, 0, "arith_pos");
        do_op(32'h1234_5678, 5'd0, 1'b0, 1'b0, 3, "shamt0");

        // Reset two edges after accept discards the operation.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd7;
        in_arith = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        do_op(32'h0000_0100, 5'd8, 1'b0, 1'b0, 0, "after_rst");

        do_op(32'h0000_000F, 5'd4, 1'b0, 1'b1, 0, "rotate");
        do_op(32'h0000_000F, 5'd4, 1'b1, 1'b1, 1, "rotate_arith");

        for (int k = 0; k < 40; k++) begin
            do_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), "rand");
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
